// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, the default
// PC step, and the "where to go once a transaction is finished" decision.
package pc_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam int INSTR_BYTES_DEF = 4;

  // A finished transaction goes to IDLE if halt is requested, otherwise it
  // starts the next fetch.
  function automatic logic [1:0] after_done(input logic halt);
    logic [1:0] nxt;
    if (halt) begin
      nxt = ST_IDLE;
    end else begin
      nxt = ST_FETCH;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus. The sequencer is the master; the memory is
// the slave. mem_req stays high with a stable mem_addr until mem_ready.
interface pc_fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter / instruction-fetch sequencer. Fetches one instruction at the
// current PC, holds it until decode accepts it, then steps the PC. Branches
// redirect the PC in any state; an outstanding request that a branch overtakes
// is completed and its data dropped (FLUSH). halt stops new fetches only.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       pc_offset,
  output logic                   pc_set,
  pc_fetch_sequencer_if.master   mem,
  output logic [WIDTH-1:0]       instr,
  output logic                   instr_valid,
  input  logic                   instr_accept,
  input  logic                   branch_req,
  input  logic                   branch_abs,
  input  logic [WIDTH-1:0]       branch_target,
  input  logic                   halt,
  output logic                   halted
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] instr_r;
  logic [WIDTH-1:0] instr_nxt_s;
  logic             instr_valid_r;
  logic             instr_valid_nxt_s;
  // Address of a request overtaken by a branch. The PC has already moved to
  // the target, so the bus address must come from here until mem_ready.
  logic [WIDTH-1:0] flush_addr_r;
  logic [WIDTH-1:0] flush_addr_nxt_s;

  // Next-state logic for the FSM, the held instruction and the flush address.
  always_comb begin
    state_nxt_s       = state_r;
    instr_nxt_s       = instr_r;
    instr_valid_nxt_s = instr_valid_r;
    flush_addr_nxt_s  = flush_addr_r;
    case (state_r)
      ST_IDLE: begin
        // Branches here only move the PC; the halt level decides leaving IDLE.
        state_nxt_s = after_done(halt);
      end
      ST_FETCH: begin
        if (branch_req) begin
          instr_valid_nxt_s = 1'b0;
          if (mem.mem_ready) begin
            state_nxt_s = after_done(halt);
          end else begin
            // The request cannot be withdrawn: wait it out and drop the data.
            state_nxt_s      = ST_FLUSH;
            flush_addr_nxt_s = pc;
          end
        end else if (mem.mem_ready) begin
          instr_nxt_s       = mem.mem_rdata;
          instr_valid_nxt_s = 1'b1;
          state_nxt_s       = ST_HOLD;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        // A branch wins over a same-cycle accept: the held word is dropped.
        if (branch_req || instr_accept) begin
          instr_valid_nxt_s = 1'b0;
          state_nxt_s       = after_done(halt);
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_FLUSH: begin
        if (mem.mem_ready) begin
          state_nxt_s = after_done(halt);
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s       = ST_IDLE;
        instr_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      instr_r       <= {WIDTH{1'b0}};
      instr_valid_r <= 1'b0;
      flush_addr_r  <= {WIDTH{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      instr_r       <= instr_nxt_s;
      instr_valid_r <= instr_valid_nxt_s;
      flush_addr_r  <= flush_addr_nxt_s;
    end
  end

  // Fetch bus and status outputs decoded from the current state.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_addr = {WIDTH{1'b0}};
    halted       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        halted = 1'b1;
      end
      ST_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc;
      end
      ST_HOLD: begin
        mem.mem_req = 1'b0;
      end
      ST_FLUSH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = flush_addr_r;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

  // PC control: branch redirect has priority over the step on accept; the PC
  // holds (add zero) otherwise.
  always_comb begin
    pc_offset = {WIDTH{1'b0}};
    pc_set    = 1'b0;
    if (branch_req) begin
      pc_offset = branch_target;
      pc_set    = branch_abs;
    end else if ((state_r == ST_HOLD) && instr_accept) begin
      pc_offset = WIDTH'(INSTR_BYTES);
      pc_set    = 1'b0;
    end else begin
      pc_offset = {WIDTH{1'b0}};
      pc_set    = 1'b0;
    end
  end

  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer. A small program-counter model closes
// the pc loop; inputs change 1 ns after the rising edge and outputs are
// checked before the next rising edge.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_offset;
  logic        pc_set;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch_req;
  logic        branch_abs;
  logic [31:0] branch_target;
  logic        halt;
  logic        halted;

  int tests_run;
  int tests_failed;

  pc_fetch_sequencer_if #(.WIDTH(32)) mem_if ();

  pc_fetch_sequencer #(.WIDTH(32), .INSTR_BYTES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .pc_offset     (pc_offset),
    .pc_set        (pc_set),
    .mem           (mem_if),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_accept  (instr_accept),
    .branch_req    (branch_req),
    .branch_abs    (branch_abs),
    .branch_target (branch_target),
    .halt          (halt),
    .halted        (halted)
  );

  // Clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program counter model: absolute load or modulo-2^32 add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 32'h0;
    end else if (pc_set) begin
      pc <= pc_offset;
    end else begin
      pc <= pc + pc_offset;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    rst                = 1'b0;
    halt               = 1'b0;
    instr_accept       = 1'b0;
    branch_req         = 1'b0;
    branch_abs         = 1'b0;
    branch_target      = 32'h0;
    mem_if.mem_ready   = 1'b0;
    mem_if.mem_rdata   = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_halted", {31'h0, halted}, 32'h1);
    chk("rst_req", {31'h0, mem_if.mem_req}, 32'h0);
    chk("rst_addr", mem_if.mem_addr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_off", pc_offset, 32'h0);
    chk("rst_set", {31'h0, pc_set}, 32'h0);
    rst = 1'b1;

    // 1: first fetch, ready one cycle after request, immediate accept
    tick();
    chk("t1_req", {31'h0, mem_if.mem_req}, 32'h1);
    chk("t1_addr", mem_if.mem_addr, 32'h0);
    chk("t1_halted", {31'h0, halted}, 32'h0);
    tick();
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h11;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t1_valid", {31'h0, instr_valid}, 32'h1);
    chk("t1_instr", instr, 32'h11);
    chk("t1_req_hold", {31'h0, mem_if.mem_req}, 32'h0);
    instr_accept = 1'b1;
    #1;
    chk("t1_off", pc_offset, 32'h4);
    chk("t1_set", {31'h0, pc_set}, 32'h0);
    tick();
    instr_accept = 1'b0;
    chk("t1_valid_drop", {31'h0, instr_valid}, 32'h0);
    chk("t1_addr2", mem_if.mem_addr, 32'h4);

    // 2: decode stalls 5 cycles
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h22;
    tick();
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", {31'h0, instr_valid}, 32'h1);
      chk("t2_instr", instr, 32'h22);
      chk("t2_off", pc_offset, 32'h0);
      chk("t2_req", {31'h0, mem_if.mem_req}, 32'h0);
      tick();
    end
    instr_accept = 1'b1;
    #1;
    chk("t2_off_acc", pc_offset, 32'h4);
    tick();
    instr_accept = 1'b0;
    chk("t2_addr_next", mem_if.mem_addr, 32'h8);

    // 3: absolute branch during FETCH with late memory
    branch_req    = 1'b1;
    branch_abs    = 1'b1;
    branch_target = 32'h100;
    #1;
    chk("t3_set", {31'h0, pc_set}, 32'h1);
    chk("t3_off", pc_offset, 32'h100);
    tick();
    branch_req = 1'b0;
    chk("t3_flush_req", {31'h0, mem_if.mem_req}, 32'h1);
    chk("t3_flush_addr", mem_if.mem_addr, 32'h8);
    chk("t3_flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("t3_pc", pc, 32'h100);
    tick();
    tick();
    chk("t3_flush_req2", {31'h0, mem_if.mem_req}, 32'h1);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'hDEAD;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t3_discard_valid", {31'h0, instr_valid}, 32'h0);
    chk("t3_discard_instr", instr, 32'h22);
    chk("t3_refetch_addr", mem_if.mem_addr, 32'h100);
    chk("t3_refetch_req", {31'h0, mem_if.mem_req}, 32'h1);

    // 4a: branch to 0x20 while FETCH completes in the same cycle
    branch_req       = 1'b1;
    branch_abs       = 1'b1;
    branch_target    = 32'h20;
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h33;
    tick();
    branch_req       = 1'b0;
    mem_if.mem_ready = 1'b0;
    chk("t4_drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_addr20", mem_if.mem_addr, 32'h20);
    chk("t4_req20", {31'h0, mem_if.mem_req}, 32'h1);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h44;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t4_instr", instr, 32'h44);
    // 4b: relative branch -8 in HOLD with a simultaneous accept
    branch_req    = 1'b1;
    branch_abs    = 1'b0;
    branch_target = 32'hFFFF_FFF8;
    instr_accept  = 1'b1;
    #1;
    chk("t4_off", pc_offset, 32'hFFFF_FFF8);
    chk("t4_set", {31'h0, pc_set}, 32'h0);
    tick();
    branch_req   = 1'b0;
    instr_accept = 1'b0;
    chk("t4_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_addr18", mem_if.mem_addr, 32'h18);

    // 5: halt raised mid-FETCH
    halt = 1'b1;
    tick();
    chk("t5_req", {31'h0, mem_if.mem_req}, 32'h1);
    chk("t5_addr", mem_if.mem_addr, 32'h18);
    chk("t5_not_halted", {31'h0, halted}, 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h55;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t5_valid", {31'h0, instr_valid}, 32'h1);
    chk("t5_instr", instr, 32'h55);
    instr_accept = 1'b1;
    #1;
    chk("t5_off", pc_offset, 32'h4);
    tick();
    instr_accept = 1'b0;
    chk("t5_halted", {31'h0, halted}, 32'h1);
    chk("t5_idle_req", {31'h0, mem_if.mem_req}, 32'h0);
    tick();
    chk("t5_halted2", {31'h0, halted}, 32'h1);
    halt = 1'b0;
    tick();
    chk("t5_resume_addr", mem_if.mem_addr, 32'h1C);
    chk("t5_resume_req", {31'h0, mem_if.mem_req}, 32'h1);

    // 6: asynchronous reset during an outstanding request
    rst  = 1'b0;
    halt = 1'b1;
    #1;
    chk("t6_req", {31'h0, mem_if.mem_req}, 32'h0);
    chk("t6_addr", mem_if.mem_addr, 32'h0);
    chk("t6_halted", {31'h0, halted}, 32'h1);
    chk("t6_instr", instr, 32'h0);
    tick();
    rst              = 1'b1;
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h66;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t6_late_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_late_instr", instr, 32'h0);
    chk("t6_late_halted", {31'h0, halted}, 32'h1);
    halt = 1'b0;
    tick();
    chk("t6_fresh_addr", mem_if.mem_addr, 32'h0);
    chk("t6_fresh_req", {31'h0, mem_if.mem_req}, 32'h1);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h77;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t6_fresh_instr", instr, 32'h77);
    chk("t6_fresh_valid", {31'h0, instr_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
